retire_writeback: RTL and testbench

Retire-side writer for the physical register file. It buffers completed instructions from the commit stage in an in-order FIFO and drains up to two entries per cycle onto the regfile's two writeback request ports (c and d). It also reports freed physical registers to the free list and keeps a retirement counter. It sits between ROB commit and the regfile write ports; the regfile's dispatch ports a/b remain read-only.

---
 rtl/retire_writeback.sv | 145 ++++++++++++++
 tb/tb_retire_writeback.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_writeback.sv
// Retire-side regfile writer: in-order commit FIFO drained up to two entries per
// cycle onto regfile write ports c/d, with free-list reporting and a retire counter.
module retire_writeback #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PREG_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_wr_en,
  input  logic [PREG_W-1:0]         in_rd,
  input  logic [PREG_W-1:0]         in_old_rd,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      wb_stall,
  input  logic                      flush,
  output logic                      wb_c_regwrite,
  output logic [PREG_W-1:0]         wb_c_rd,
  output logic [DATA_W-1:0]         wb_c_data,
  output logic                      wb_d_regwrite,
  output logic [PREG_W-1:0]         wb_d_rd,
  output logic [DATA_W-1:0]         wb_d_data,
  output logic                      free_valid_0,
  output logic [PREG_W-1:0]         free_preg_0,
  output logic                      free_valid_1,
  output logic [PREG_W-1:0]         free_preg_1,
  output logic [15:0]               retired_count,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic              mem_wr_en_q  [DEPTH];
  logic [PREG_W-1:0] mem_rd_q     [DEPTH];
  logic [PREG_W-1:0] mem_old_rd_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q   [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head1;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       retired_q, retired_d;

  logic              c_we_q, c_we_d, d_we_q, d_we_d;
  logic [PREG_W-1:0] c_rd_q, c_rd_d, d_rd_q, d_rd_d;
  logic [DATA_W-1:0] c_data_q, c_data_d, d_data_q, d_data_d;
  logic              fv0_q, fv0_d, fv1_q, fv1_d;
  logic [PREG_W-1:0] fp0_q, fp0_d, fp1_q, fp1_d;

  logic              push, pop_c, pop_d;
  logic [1:0]        n_pop;

  assign in_ready = (count_q != CNT_W'(DEPTH));

  always_comb begin
    head1  = head_q + PTR_W'(1);
    push   = in_valid && in_ready && !flush;
    pop_c  = !flush && !wb_stall && (count_q != '0);
    pop_d  = !flush && !wb_stall && (count_q >= CNT_W'(2));
    n_pop  = {1'b0, pop_c} + {1'b0, pop_d};

    c_we_d = pop_c && mem_wr_en_q[head_q] && (mem_rd_q[head_q] != '0);
    d_we_d = pop_d && mem_wr_en_q[head1]  && (mem_rd_q[head1]  != '0);
    // Same destination in one drain: only the younger write survives.
    if (c_we_d && d_we_d && (mem_rd_q[head_q] == mem_rd_q[head1]))
      c_we_d = 1'b0;

    fv0_d    = pop_c && mem_wr_en_q[head_q] && (mem_old_rd_q[head_q] != '0);
    fv1_d    = pop_d && mem_wr_en_q[head1]  && (mem_old_rd_q[head1]  != '0);

    c_rd_d   = pop_c ? mem_rd_q[head_q]     : c_rd_q;
    c_data_d = pop_c ? mem_data_q[head_q]   : c_data_q;
    fp0_d    = pop_c ? mem_old_rd_q[head_q] : fp0_q;
    d_rd_d   = pop_d ? mem_rd_q[head1]      : d_rd_q;
    d_data_d = pop_d ? mem_data_q[head1]    : d_data_q;
    fp1_d    = pop_d ? mem_old_rd_q[head1]  : fp1_q;

    head_d    = head_q + PTR_W'(n_pop);
    tail_d    = push ? tail_q + PTR_W'(1) : tail_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(n_pop);
    retired_d = retired_q + 16'(n_pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wr_en_q[tail_q]  <= in_wr_en;
      mem_rd_q[tail_q]     <= in_rd;
      mem_old_rd_q[tail_q] <= in_old_rd;
      mem_data_q[tail_q]   <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      retired_q <= '0;
      c_we_q    <= 1'b0;
      d_we_q    <= 1'b0;
      c_rd_q    <= '0;
      d_rd_q    <= '0;
      c_data_q  <= '0;
      d_data_q  <= '0;
      fv0_q     <= 1'b0;
      fv1_q     <= 1'b0;
      fp0_q     <= '0;
      fp1_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      retired_q <= retired_d;
      c_we_q    <= c_we_d;
      d_we_q    <= d_we_d;
      c_rd_q    <= c_rd_d;
      d_rd_q    <= d_rd_d;
      c_data_q  <= c_data_d;
      d_data_q  <= d_data_d;
      fv0_q     <= fv0_d;
      fv1_q     <= fv1_d;
      fp0_q     <= fp0_d;
      fp1_q     <= fp1_d;
    end
  end

  assign wb_c_regwrite = c_we_q;
  assign wb_c_rd       = c_rd_q;
  assign wb_c_data     = c_data_q;
  assign wb_d_regwrite = d_we_q;
  assign wb_d_rd       = d_rd_q;
  assign wb_d_data     = d_data_q;
  assign free_valid_0  = fv0_q;
  assign free_preg_0   = fp0_q;
  assign free_valid_1  = fv1_q;
  assign free_preg_1   = fp1_q;
  assign retired_count = retired_q;
  assign occupancy     = count_q;

endmodule

// File: tb/tb_retire_writeback.sv
// Directed self-checking bench for retire_writeback.
module tb_retire_writeback;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_wr_en, wb_stall, flush;
  logic [6:0]  in_rd, in_old_rd;
  logic [31:0] in_data;
  logic        wb_c_regwrite, wb_d_regwrite, free_valid_0, free_valid_1;
  logic [6:0]  wb_c_rd, wb_d_rd, free_preg_0, free_preg_1;
  logic [31:0] wb_c_data, wb_d_data;
  logic [15:0] retired_count;
  logic [3:0]  occupancy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  retire_writeback #(.DEPTH(8), .PREG_W(7), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_wr_en(in_wr_en), .in_rd(in_rd), .in_old_rd(in_old_rd), .in_data(in_data),
    .wb_stall(wb_stall), .flush(flush),
    .wb_c_regwrite(wb_c_regwrite), .wb_c_rd(wb_c_rd), .wb_c_data(wb_c_data),
    .wb_d_regwrite(wb_d_regwrite), .wb_d_rd(wb_d_rd), .wb_d_data(wb_d_data),
    .free_valid_0(free_valid_0), .free_preg_0(free_preg_0),
    .free_valid_1(free_valid_1), .free_preg_1(free_preg_1),
    .retired_count(retired_count), .occupancy(occupancy)
  );

  wire [39:0] slot_c = {wb_c_regwrite, wb_c_rd, wb_c_data};
  wire [39:0] slot_d = {wb_d_regwrite, wb_d_rd, wb_d_data};
  wire [15:0] frees  = {free_valid_0, free_preg_0, free_valid_1, free_preg_1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic we, input int rd, input int old, input int data);
    in_valid  = v;
    in_wr_en  = we;
    in_rd     = 7'(rd);
    in_old_rd = 7'(old);
    in_data   = 32'(data);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wb_stall = 1'b0;
    set_in(1'b0, 1'b0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({slot_c, slot_d, frees} !== 96'd0) $display("FAIL reset_outputs: got %h want 0", {slot_c, slot_d, frees});
    else pass_cnt++;
    total_cnt++;
    if ({in_ready, occupancy, retired_count} !== {1'b1, 4'd0, 16'd0})
      $display("FAIL reset_state: got rdy=%0b occ=%0d ret=%0d want 1/0/0", in_ready, occupancy, retired_count);
    else pass_cnt++;
  endtask

  task automatic test_basic_write();
    set_in(1'b1, 1'b1, 5, 12, 32'hDEADBEEF);
    tick();
    set_in(1'b0, 1'b0, 0, 0, 0);
    total_cnt++;
    if (occupancy !== 4'd1 || wb_c_regwrite !== 1'b0) $display("FAIL basic_push: got occ=%0d cwe=%0b want 1/0", occupancy, wb_c_regwrite);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (slot_c !== {1'b1, 7'd5, 32'hDEADBEEF}) $display("FAIL basic_c: got %h want %h", slot_c, {1'b1, 7'd5, 32'hDEADBEEF});
    else pass_cnt++;
    total_cnt++;
    if ({frees[15:8], wb_d_regwrite, free_valid_1} !== {1'b1, 7'd12, 1'b0, 1'b0})
      $display("FAIL basic_free: got f0=%0b/%0d dwe=%0b f1=%0b want 1/12/0/0", free_valid_0, free_preg_0, wb_d_regwrite, free_valid_1);
    else pass_cnt++;
    total_cnt++;
    if (retired_count !== 16'd1 || occupancy !== 4'd0) $display("FAIL basic_count: got ret=%0d occ=%0d want 1/0", retired_count, occupancy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({wb_c_regwrite, free_valid_0} !== 2'b00) $display("FAIL basic_pulse: got cwe=%0b f0=%0b want 0/0", wb_c_regwrite, free_valid_0);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    wb_stall = 1'b1;
    set_in(1'b1, 1'b1, 9, 20, 1); tick();
    set_in(1'b1, 1'b1, 9, 21, 2); tick();
    set_in(1'b1, 1'b1, 3, 22, 3); tick();
    set_in(1'b0, 1'b0, 0, 0, 0);
    total_cnt++;
    if (occupancy !== 4'd3 || wb_c_regwrite !== 1'b0) $display("FAIL stall_hold: got occ=%0d cwe=%0b want 3/0", occupancy, wb_c_regwrite);
    else pass_cnt++;
    wb_stall = 1'b0;
    tick();
    total_cnt++;
    if (slot_c !== {1'b0, 7'd9, 32'd1}) $display("FAIL coll_c: got %h want %h", slot_c, {1'b0, 7'd9, 32'd1});
    else pass_cnt++;
    total_cnt++;
    if (slot_d !== {1'b1, 7'd9, 32'd2}) $display("FAIL coll_d: got %h want %h", slot_d, {1'b1, 7'd9, 32'd2});
    else pass_cnt++;
    total_cnt++;
    if (frees !== {1'b1, 7'd20, 1'b1, 7'd21}) $display("FAIL coll_free: got %h want %h", frees, {1'b1, 7'd20, 1'b1, 7'd21});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({slot_c, wb_d_regwrite} !== {1'b1, 7'd3, 32'd3, 1'b0}) $display("FAIL coll_next: got %h want %h", {slot_c, wb_d_regwrite}, {1'b1, 7'd3, 32'd3, 1'b0});
    else pass_cnt++;
    total_cnt++;
    if ({wb_d_rd, wb_d_data} !== {7'd9, 32'd2}) $display("FAIL coll_d_hold: got %h want %h", {wb_d_rd, wb_d_data}, {7'd9, 32'd2});
    else pass_cnt++;
    total_cnt++;
    if (retired_count !== 16'd4) $display("FAIL coll_count: got %0d want 4", retired_count);
    else pass_cnt++;
  endtask

  task automatic test_x0_nonwriter();
    wb_stall = 1'b1;
    set_in(1'b1, 1'b1, 0, 0, 32'h55); tick();
    set_in(1'b1, 1'b0, 7, 6, 32'h66); tick();
    set_in(1'b0, 1'b0, 0, 0, 0);
    wb_stall = 1'b0;
    tick();
    total_cnt++;
    if ({wb_c_regwrite, wb_d_regwrite, free_valid_0, free_valid_1} !== 4'b0000)
      $display("FAIL x0_flags: got %b want 0000", {wb_c_regwrite, wb_d_regwrite, free_valid_0, free_valid_1});
    else pass_cnt++;
    total_cnt++;
    if ({wb_c_rd, wb_d_rd, wb_d_data} !== {7'd0, 7'd7, 32'h66}) $display("FAIL x0_copy: got %h want %h", {wb_c_rd, wb_d_rd, wb_d_data}, {7'd0, 7'd7, 32'h66});
    else pass_cnt++;
    total_cnt++;
    if (retired_count !== 16'd6) $display("FAIL x0_count: got %0d want 6", retired_count);
    else pass_cnt++;
  endtask

  task automatic fill_and_drain(input int base, input int exp_ret);
    wb_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b1, base + i, 40 + i, 32'h100 + base + i);
      tick();
    end
    total_cnt++;
    if ({in_ready, occupancy} !== {1'b0, 4'd8}) $display("FAIL full_%0d: got rdy=%0b occ=%0d want 0/8", base, in_ready, occupancy);
    else pass_cnt++;
    set_in(1'b1, 1'b1, 99, 99, 32'hBAD);
    tick();
    set_in(1'b0, 1'b0, 0, 0, 0);
    total_cnt++;
    if (occupancy !== 4'd8) $display("FAIL full_ignore_%0d: got occ=%0d want 8", base, occupancy);
    else pass_cnt++;
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if ({slot_c, slot_d} !== {1'b1, 7'(base + 2*k), 32'(32'h100 + base + 2*k), 1'b1, 7'(base + 2*k + 1), 32'(32'h100 + base + 2*k + 1)})
        $display("FAIL drain_%0d_%0d: got c=%h d=%h", base, k, slot_c, slot_d);
      else pass_cnt++;
    end
    total_cnt++;
    if ({occupancy, retired_count} !== {4'd0, 16'(exp_ret)}) $display("FAIL drain_end_%0d: got occ=%0d ret=%0d want 0/%0d", base, occupancy, retired_count, exp_ret);
    else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    fill_and_drain(10, 14);
    fill_and_drain(20, 22);
  endtask

  task automatic test_flush();
    wb_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b1, 30 + i, 50 + i, 32'h300 + i);
      tick();
    end
    wb_stall = 1'b0;
    set_in(1'b1, 1'b1, 36, 56, 32'h306);
    tick();
    total_cnt++;
    if ({occupancy, wb_c_regwrite, wb_c_rd, wb_d_rd, retired_count} !== {4'd5, 1'b1, 7'd30, 7'd31, 16'd24})
      $display("FAIL preflush: got occ=%0d cwe=%0b crd=%0d drd=%0d ret=%0d", occupancy, wb_c_regwrite, wb_c_rd, wb_d_rd, retired_count);
    else pass_cnt++;
    flush = 1'b1;
    set_in(1'b1, 1'b1, 37, 57, 32'h307);
    tick();
    flush = 1'b0;
    set_in(1'b0, 1'b0, 0, 0, 0);
    total_cnt++;
    if ({occupancy, in_ready, retired_count} !== {4'd0, 1'b1, 16'd24})
      $display("FAIL flush_state: got occ=%0d rdy=%0b ret=%0d want 0/1/24", occupancy, in_ready, retired_count);
    else pass_cnt++;
    total_cnt++;
    if ({wb_c_regwrite, wb_d_regwrite, free_valid_0, free_valid_1} !== 4'b0000)
      $display("FAIL flush_outs: got %b want 0000", {wb_c_regwrite, wb_d_regwrite, free_valid_0, free_valid_1});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({wb_c_regwrite, occupancy, retired_count} !== {1'b0, 4'd0, 16'd24})
      $display("FAIL flush_after: got cwe=%0b occ=%0d ret=%0d want 0/0/24", wb_c_regwrite, occupancy, retired_count);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 1'b1, 4, 8, 32'hA); tick();
    set_in(1'b1, 1'b1, 6, 9, 32'hB); tick();
    set_in(1'b0, 1'b0, 0, 0, 0);
    total_cnt++;
    if ({wb_c_regwrite, occupancy, retired_count} !== {1'b1, 4'd1, 16'd25})
      $display("FAIL prereset: got cwe=%0b occ=%0d ret=%0d want 1/1/25", wb_c_regwrite, occupancy, retired_count);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({wb_c_regwrite, free_valid_0, wb_c_rd, occupancy, retired_count, in_ready} !== {1'b0, 1'b0, 7'd0, 4'd0, 16'd0, 1'b1})
      $display("FAIL async_reset: got cwe=%0b f0=%0b crd=%0d occ=%0d ret=%0d rdy=%0b", wb_c_regwrite, free_valid_0, wb_c_rd, occupancy, retired_count, in_ready);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({wb_c_regwrite, occupancy, retired_count} !== {1'b0, 4'd0, 16'd0})
      $display("FAIL post_reset: got cwe=%0b occ=%0d ret=%0d want 0/0/0", wb_c_regwrite, occupancy, retired_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_collision();
    test_x0_nonwriter();
    test_full_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
